// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the five-stage processor pipeline registers:
// datapath widths, condition-code bit positions, the EX/MEM control
// bundle and small helpers used by the EX/MEM stage register.
package pipeline_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int FLAG_W     = 3;

  // Condition-code register bit positions
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

  // Memory / write-back control carried from EX into MEM
  typedef struct packed {
    logic RegWrite;
    logic MemRead;
    logic MemWrite;
  } ex_mem_ctrl_t;

  // What the stage register does on a given clock edge
  typedef enum logic [1:0] {
    ACT_RESET = 2'd0,
    ACT_FLUSH = 2'd1,
    ACT_HOLD  = 2'd2,
    ACT_LOAD  = 2'd3
  } stage_act_t;

  // Resolve the per-edge priority: reset, then flush, then stall, then load.
  function automatic stage_act_t decode_act(input logic rst,
                                            input logic flush,
                                            input logic stall);
    stage_act_t act;
    if (rst) begin
      act = ACT_RESET;
    end else if (flush) begin
      act = ACT_FLUSH;
    end else if (stall) begin
      act = ACT_HOLD;
    end else begin
      act = ACT_LOAD;
    end
    return act;
  endfunction

  // A bubble must never carry live control bits into MEM.
  function automatic ex_mem_ctrl_t gate_ctrl(input ex_mem_ctrl_t ctrl,
                                             input logic valid);
    ex_mem_ctrl_t gated;
    if (valid) begin
      gated = ctrl;
    end else begin
      gated = 3'b000;
    end
    return gated;
  endfunction

  // Only ALU results are forwardable from MEM; load data is not yet available.
  function automatic logic fwd_ok(input ex_mem_ctrl_t ctrl,
                                  input logic valid);
    return valid & ctrl.RegWrite & ~ctrl.MemRead;
  endfunction

endpackage : pipeline_pkg

// File: rtl/ex_mem_stage_reg_ccr.sv
// ccr_reg
// Architectural condition-code register {V,N,Z}. Loads new flags when
// update_en is high. When built with EX_MEM_CCR_SHADOW_EN it also holds a
// shadow copy for interrupt entry/exit: save copies CCR into the shadow,
// restore copies the shadow into CCR (beating any flag update), and both
// together swap the two. Without the macro, save/restore are ignored.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   update_en   load flag_in into CCR this edge
//   flag_in     new flags from the ALU
//   save        copy CCR into shadow (macro builds only)
//   restore     copy shadow into CCR (macro builds only)
//   ccr         current architectural flags
module ccr_reg #(
  parameter int FLAG_W = pipeline_pkg::FLAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              update_en,
  input  logic [FLAG_W-1:0] flag_in,
  input  logic              save,
  input  logic              restore,
  output logic [FLAG_W-1:0] ccr
);

  logic [FLAG_W-1:0] ccr_r;

`ifdef EX_MEM_CCR_SHADOW_EN
  logic [FLAG_W-1:0] shadow_r;

  // CCR: restore overrides the ALU update and ignores stall/flush
  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_r <= {FLAG_W{1'b0}};
    end else if (restore) begin
      ccr_r <= shadow_r;
    end else if (update_en) begin
      ccr_r <= flag_in;
    end else begin
      ccr_r <= ccr_r;
    end
  end

  // Shadow captures the pre-edge CCR, so save+restore swaps the two
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r <= {FLAG_W{1'b0}};
    end else if (save) begin
      shadow_r <= ccr_r;
    end else begin
      shadow_r <= shadow_r;
    end
  end
`else
  logic unused_shadow_ctl;
  assign unused_shadow_ctl = save ^ restore;

  // CCR: plain enabled register
  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_r <= {FLAG_W{1'b0}};
    end else if (update_en) begin
      ccr_r <= flag_in;
    end else begin
      ccr_r <= ccr_r;
    end
  end
`endif

  assign ccr = ccr_r;

endmodule : ccr_reg

// File: rtl/ex_mem_stage_reg_chk.sv
// ex_mem_stage_reg_chk
// Run-time invariants of the EX/MEM stage register, kept apart from the
// datapath. Observes registered state only.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   mem_valid   registered valid bit
//   mem_ctrl    registered {RegWrite, MemRead, MemWrite}
//   fwd_valid   forwarding-candidate flag
module ex_mem_stage_reg_chk (
  input logic       clk,
  input logic       rst,
  input logic       mem_valid,
  input logic [2:0] mem_ctrl,
  input logic       fwd_valid
);

  // A bubble never carries control bits
  a_bubble_no_ctrl: assert property (@(posedge clk) disable iff (rst)
    !mem_valid |-> (mem_ctrl == 3'b000));

  // Forwarding only for valid, register-writing, non-load instructions
  a_fwd_rule: assert property (@(posedge clk) disable iff (rst)
    fwd_valid == (mem_valid & mem_ctrl[2] & ~mem_ctrl[1]));

endmodule : ex_mem_stage_reg_chk

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg
// EX/MEM pipeline register. Captures the ALU result, destination index,
// store data and memory/write-back control one cycle after EX, owns the
// architectural CCR (via ccr_reg), obeys stall/flush from the hazard unit
// and drives the EX/MEM forwarding path from registered state only.
// Optional feature: define EX_MEM_CCR_SHADOW_EN to add the interrupt CCR
// shadow register (ccr_save / ccr_restore); otherwise those inputs are ignored.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall, flush              hazard-unit controls (flush wins over stall)
//   EX_valid                  EX holds a real instruction
//   ALU_Result, ALU_CCR       ALU output and {V,N,Z} flags
//   flag_en                   instruction updates CCR
//   Rdst_addr, store_data     destination index, store value
//   RegWrite/MemRead/MemWrite control bits
//   ccr_save, ccr_restore     interrupt flag save/restore
//   MEM_*                     registered stage outputs
//   CCR                       architectural flags
//   fwd_valid/addr/data       EX/MEM forwarding candidate
module ex_mem_stage_reg #(
  parameter int DATA_W     = pipeline_pkg::DATA_W,
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
  parameter int FLAG_W     = pipeline_pkg::FLAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  EX_valid,
  input  logic [DATA_W-1:0]     ALU_Result,
  input  logic [FLAG_W-1:0]     ALU_CCR,
  input  logic                  flag_en,
  input  logic [REG_ADDR_W-1:0] Rdst_addr,
  input  logic [DATA_W-1:0]     store_data,
  input  logic                  RegWrite,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  ccr_save,
  input  logic                  ccr_restore,
  output logic                  MEM_valid,
  output logic [DATA_W-1:0]     MEM_ALU_Result,
  output logic [REG_ADDR_W-1:0] MEM_Rdst_addr,
  output logic [DATA_W-1:0]     MEM_store_data,
  output logic                  MEM_RegWrite,
  output logic                  MEM_MemRead,
  output logic                  MEM_MemWrite,
  output logic [FLAG_W-1:0]     CCR,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data
);

  import pipeline_pkg::*;

  stage_act_t            act_s;
  ex_mem_ctrl_t          ctrl_in_s;
  logic                  ccr_update_s;

  logic                  valid_r;
  logic [DATA_W-1:0]     result_r;
  logic [REG_ADDR_W-1:0] rdst_r;
  logic [DATA_W-1:0]     store_r;
  ex_mem_ctrl_t          ctrl_r;

  assign act_s     = decode_act(rst, flush, stall);
  assign ctrl_in_s = '{RegWrite: RegWrite, MemRead: MemRead, MemWrite: MemWrite};

  // Flags retire only with a real, flag-setting instruction that actually loads
  assign ccr_update_s = (act_s == ACT_LOAD) & EX_valid & flag_en;

  // Pipeline register; a flush clears only valid/control, data may go stale
  always_ff @(posedge clk) begin
    case (act_s)
      ACT_RESET: begin
        valid_r  <= 1'b0;
        result_r <= {DATA_W{1'b0}};
        rdst_r   <= {REG_ADDR_W{1'b0}};
        store_r  <= {DATA_W{1'b0}};
        ctrl_r   <= 3'b000;
      end
      ACT_FLUSH: begin
        valid_r  <= 1'b0;
        result_r <= result_r;
        rdst_r   <= rdst_r;
        store_r  <= store_r;
        ctrl_r   <= 3'b000;
      end
      ACT_LOAD: begin
        valid_r  <= EX_valid;
        result_r <= ALU_Result;
        rdst_r   <= Rdst_addr;
        store_r  <= store_data;
        ctrl_r   <= gate_ctrl(ctrl_in_s, EX_valid);
      end
      default: begin
        valid_r  <= valid_r;
        result_r <= result_r;
        rdst_r   <= rdst_r;
        store_r  <= store_r;
        ctrl_r   <= ctrl_r;
      end
    endcase
  end

  ccr_reg #(
    .FLAG_W (FLAG_W)
  ) u_ccr (
    .clk       (clk),
    .rst       (rst),
    .update_en (ccr_update_s),
    .flag_in   (ALU_CCR),
    .save      (ccr_save),
    .restore   (ccr_restore),
    .ccr       (CCR)
  );

  assign MEM_valid      = valid_r;
  assign MEM_ALU_Result = result_r;
  assign MEM_Rdst_addr  = rdst_r;
  assign MEM_store_data = store_r;
  assign MEM_RegWrite   = ctrl_r.RegWrite;
  assign MEM_MemRead    = ctrl_r.MemRead;
  assign MEM_MemWrite   = ctrl_r.MemWrite;

  // Forwarding is a pure function of registered state
  assign fwd_valid = fwd_ok(ctrl_r, valid_r);
  assign fwd_addr  = rdst_r;
  assign fwd_data  = result_r;

  ex_mem_stage_reg_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (valid_r),
    .mem_ctrl  (ctrl_r),
    .fwd_valid (fwd_valid)
  );

endmodule : ex_mem_stage_reg

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid, flag_en;
  logic [15:0] alu_result, store_data;
  logic [2:0]  alu_ccr, rdst_addr;
  logic        reg_write, mem_read, mem_write, ccr_save, ccr_restore;

  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [15:0] mem_alu_result, mem_store_data, fwd_data;
  logic [2:0]  mem_rdst_addr, ccr, fwd_addr;
  logic        fwd_valid;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic        m_valid, m_rw, m_mr, m_mw;
  logic [15:0] m_res, m_sd;
  logic [2:0]  m_rd, m_ccr, m_shadow;

  ex_mem_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .EX_valid(ex_valid),
    .ALU_Result(alu_result), .ALU_CCR(alu_ccr), .flag_en(flag_en),
    .Rdst_addr(rdst_addr), .store_data(store_data), .RegWrite(reg_write),
    .MemRead(mem_read), .MemWrite(mem_write), .ccr_save(ccr_save),
    .ccr_restore(ccr_restore), .MEM_valid(mem_valid),
    .MEM_ALU_Result(mem_alu_result), .MEM_Rdst_addr(mem_rdst_addr),
    .MEM_store_data(mem_store_data), .MEM_RegWrite(mem_reg_write),
    .MEM_MemRead(mem_mem_read), .MEM_MemWrite(mem_mem_write), .CCR(ccr),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  // Advance the model by one edge using the current inputs
  task automatic model_edge();
    logic [2:0] old_ccr, old_sh;
    old_ccr = m_ccr;
    old_sh  = m_shadow;
    if (rst) begin
      {m_valid, m_rw, m_mr, m_mw} = 4'b0000;
      m_res = 16'h0000; m_sd = 16'h0000; m_rd = 3'd0;
      m_ccr = 3'b000; m_shadow = 3'b000;
    end else begin
      if (flush) begin
        {m_valid, m_rw, m_mr, m_mw} = 4'b0000;
      end else if (!stall) begin
        m_valid = ex_valid;
        m_res = alu_result; m_sd = store_data; m_rd = rdst_addr;
        m_rw = ex_valid && reg_write;
        m_mr = ex_valid && mem_read;
        m_mw = ex_valid && mem_write;
        if (ex_valid && flag_en) m_ccr = alu_ccr;
      end
`ifdef EX_MEM_CCR_SHADOW_EN
      if (ccr_save) m_shadow = old_ccr;
      if (ccr_restore) m_ccr = old_sh;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; flag_en = 1'b0;
    alu_result = 16'h0000; store_data = 16'h0000; alu_ccr = 3'b000;
    rdst_addr = 3'd0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    ccr_save = 1'b0; ccr_restore = 1'b0;
  endtask

  task automatic set_instr(input logic [15:0] res, input logic [2:0] fl,
                           input logic fen, input logic [2:0] rd,
                           input logic rw, input logic mr, input logic mw);
    ex_valid = 1'b1; alu_result = res; alu_ccr = fl; flag_en = fen;
    rdst_addr = rd; reg_write = rw; mem_read = mr; mem_write = mw;
    store_data = 16'h5A5A;
  endtask

  task automatic test_reset();
    idle_inputs();
    ex_valid = 1'b1; reg_write = 1'b1; alu_result = 16'hFFFF;
    alu_ccr = 3'b111; flag_en = 1'b1; rst = 1'b1;
    tick(); tick();
    checks++;
    if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_alu_result,
         mem_rdst_addr, mem_store_data} !== 42'd0) begin
      errors++;
      $display("FAIL reset_mem: got valid=%b res=%h rd=%0d sd=%h ctrl=%b%b%b want all 0",
               mem_valid, mem_alu_result, mem_rdst_addr, mem_store_data,
               mem_reg_write, mem_mem_read, mem_mem_write);
    end
    checks++;
    if (ccr !== 3'b000 || fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ccr_fwd: got ccr=%b fwd_valid=%b want 000/0", ccr, fwd_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    idle_inputs();
    set_instr(16'h8000, 3'b110, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (mem_alu_result !== 16'h8000 || ccr !== 3'b110 || mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_capture: got res=%h ccr=%b valid=%b want 8000/110/1",
               mem_alu_result, ccr, mem_valid);
    end
    checks++;
    if (fwd_valid !== 1'b1 || fwd_addr !== 3'd3 || fwd_data !== 16'h8000) begin
      errors++;
      $display("FAIL add_fwd: got v=%b a=%0d d=%h want 1/3/8000",
               fwd_valid, fwd_addr, fwd_data);
    end
  endtask

  task automatic test_stall();
    set_instr(16'h0001, 3'b000, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (mem_alu_result !== 16'h8000 || ccr !== 3'b110 || mem_rdst_addr !== 3'd3) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got res=%h ccr=%b rd=%0d want 8000/110/3",
                 i, mem_alu_result, ccr, mem_rdst_addr);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (mem_alu_result !== 16'h0001 || ccr !== 3'b000 || mem_rdst_addr !== 3'd5) begin
      errors++;
      $display("FAIL stall_release: got res=%h ccr=%b rd=%0d want 0001/000/5",
               mem_alu_result, ccr, mem_rdst_addr);
    end
  endtask

  task automatic test_flush();
    set_instr(16'h1234, 3'b001, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1);
    stall = 1'b1; flush = 1'b1;
    tick();
    checks++;
    if (mem_valid !== 1'b0 || mem_reg_write !== 1'b0 || mem_mem_write !== 1'b0 ||
        fwd_valid !== 1'b0 || ccr !== 3'b000) begin
      errors++;
      $display("FAIL flush_bubble: got valid=%b rw=%b mw=%b fwd=%b ccr=%b want 0/0/0/0/000",
               mem_valid, mem_reg_write, mem_mem_write, fwd_valid, ccr);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_load_no_fwd();
    set_instr(16'h0040, 3'b000, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (mem_mem_read !== 1'b1 || mem_reg_write !== 1'b1 || fwd_valid !== 1'b0 ||
        mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_no_fwd: got mr=%b rw=%b fwd=%b valid=%b want 1/1/0/1",
               mem_mem_read, mem_reg_write, fwd_valid, mem_valid);
    end
  endtask

  task automatic test_invalid_bubble();
    set_instr(16'h7777, 3'b101, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1);
    ex_valid = 1'b0;
    tick();
    checks++;
    if (mem_valid !== 1'b0 || mem_reg_write !== 1'b0 || mem_mem_write !== 1'b0 ||
        ccr !== 3'b000 || mem_alu_result !== 16'h7777) begin
      errors++;
      $display("FAIL invalid_bubble: got valid=%b rw=%b mw=%b ccr=%b res=%h want 0/0/0/000/7777",
               mem_valid, mem_reg_write, mem_mem_write, ccr, mem_alu_result);
    end
  endtask

  task automatic test_shadow();
    idle_inputs();
    set_instr(16'h0002, 3'b010, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
    flag_en = 1'b0; ccr_save = 1'b1;
    tick();
    ccr_save = 1'b0; flag_en = 1'b1; alu_ccr = 3'b001;
    tick();
    checks++;
    if (ccr !== 3'b001) begin
      errors++;
      $display("FAIL shadow_update: got ccr=%b want 001", ccr);
    end
    ccr_restore = 1'b1; alu_ccr = 3'b100;
    tick();
    ccr_restore = 1'b0;
    checks++;
`ifdef EX_MEM_CCR_SHADOW_EN
    if (ccr !== 3'b010) begin
      errors++;
      $display("FAIL shadow_restore: got ccr=%b want 010", ccr);
    end
`else
    if (ccr !== 3'b100) begin
      errors++;
      $display("FAIL restore_ignored: got ccr=%b want 100", ccr);
    end
`endif
  endtask

  task automatic test_reset_mid_stall();
    set_instr(16'hBEEF, 3'b111, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    stall = 1'b1; flush = 1'b1; rst = 1'b1;
    tick();
    checks++;
    if (mem_alu_result !== 16'h0000 || ccr !== 3'b000 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall: got res=%h ccr=%b valid=%b want 0000/000/0",
               mem_alu_result, ccr, mem_valid);
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    checks++;
    if (mem_alu_result !== 16'hBEEF || ccr !== 3'b111 || fwd_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_load: got res=%h ccr=%b fwd=%b want BEEF/111/1",
               mem_alu_result, ccr, fwd_valid);
    end
  endtask

  task automatic test_random();
    logic [44:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 39) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 5) == 0);
      ex_valid    = ($urandom_range(0, 4) != 0);
      flag_en     = $urandom_range(0, 1);
      alu_result  = 16'($urandom);
      store_data  = 16'($urandom);
      alu_ccr     = 3'($urandom);
      rdst_addr   = 3'($urandom);
      reg_write   = $urandom_range(0, 1);
      mem_read    = $urandom_range(0, 1);
      mem_write   = $urandom_range(0, 1);
      ccr_save    = ($urandom_range(0, 7) == 0);
      ccr_restore = ($urandom_range(0, 7) == 0);
      tick();
      got = {mem_valid, mem_alu_result, mem_rdst_addr, mem_store_data,
             mem_reg_write, mem_mem_read, mem_mem_write, ccr, fwd_valid};
      exp = {m_valid, m_res, m_rd, m_sd, m_rw, m_mr, m_mw, m_ccr,
             m_valid & m_rw & ~m_mr};
      checks++;
      if (got !== exp || fwd_addr !== m_rd || fwd_data !== m_res) begin
        errors++;
        $display("FAIL random[%0d]: got %h fwd=%0d/%h want %h fwd=%0d/%h",
                 i, got, fwd_addr, fwd_data, exp, m_rd, m_res);
      end
    end
  endtask

  initial begin
    idle_inputs();
    m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
    m_res = 16'h0000; m_sd = 16'h0000; m_rd = 3'd0;
    m_ccr = 3'b000; m_shadow = 3'b000;
    #2;
    test_reset();
    test_add();
    test_stall();
    test_flush();
    test_load_no_fwd();
    test_invalid_bubble();
    test_shadow();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ex_mem_stage_reg
